// File: rtl/cell_editor.sv
// Cursor control and read-modify-write cell editor feeding the game RAM write port.
// Move pulses steer the cursor; digit or clear requests rewrite one column of the row word.
module cell_editor #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        digitValid,
    input  logic [2:0]  digitIn,
    input  logic        clearReq,
    input  logic        gameLocked,
    output logic [1:0]  RamAddr,
    input  logic [23:0] RamDatIn,
    output logic [23:0] RamDatOut,
    output logic        RamWe,
    output logic [1:0]  cursorRow,
    output logic [1:0]  cursorCol,
    output logic        busy,
    output logic        rejected
);
    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t      state;
    logic [1:0]  latCnt;
    logic [1:0]  editCol;
    logic [2:0]  editDigit;
    logic        editClear;
    logic [1:0]  nextRow;
    logic [1:0]  nextCol;
    logic [23:0] editedWord;
    logic        refuse;

    // Opposing pulses on one axis cancel; the two axes are independent.
    always_comb begin
        nextRow = cursorRow;
        nextCol = cursorCol;
        if (btnDown && !btnUp)
            nextRow = cursorRow + 2'd1;
        else if (btnUp && !btnDown)
            nextRow = cursorRow - 2'd1;
        if (btnRight && !btnLeft)
            nextCol = cursorCol + 2'd1;
        else if (btnLeft && !btnRight)
            nextCol = cursorCol - 2'd1;
    end

    always_comb begin
        editedWord = RamDatIn;
        editedWord[{editCol, 2'b00} +: 4] = editClear ? 4'd0 : {1'b0, editDigit};
        editedWord[{3'b100, editCol}]     = editClear;
        refuse = RamDatIn[{3'b101, editCol}] || gameLocked ||
                 (!editClear && (editDigit == 3'd0 || editDigit > 3'd4));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            latCnt    <= '0;
            editCol   <= '0;
            editDigit <= '0;
            editClear <= 1'b0;
            RamAddr   <= '0;
            RamDatOut <= '0;
            RamWe     <= 1'b0;
            cursorRow <= '0;
            cursorCol <= '0;
            busy      <= 1'b0;
            rejected  <= 1'b0;
        end else begin
            RamWe    <= 1'b0;
            rejected <= 1'b0;
            case (state)
                IDLE: begin
                    if (digitValid || clearReq) begin
                        editCol   <= cursorCol;
                        editClear <= clearReq;
                        editDigit <= digitIn;
                        RamAddr   <= cursorRow;
                        latCnt    <= LAT_LOAD;
                        busy      <= 1'b1;
                        state     <= RD;
                    end else begin
                        cursorRow <= nextRow;
                        cursorCol <= nextCol;
                    end
                end
                RD: begin
                    if (latCnt == '0)
                        state <= CAP;
                    else
                        latCnt <= latCnt - 2'd1;
                end
                CAP: begin
                    // Word is evaluated straight off RamDatIn so the registered
                    // write/refuse outputs are visible during the WR cycle.
                    if (refuse) begin
                        rejected <= 1'b1;
                    end else begin
                        RamWe     <= 1'b1;
                        RamDatOut <= editedWord;
                    end
                    state <= WR;
                end
                WR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_editor.sv
// Bench for cell_editor: two instances (RD_LAT 1 and 3) share stimulus, each with its
// own RAM, checked every cycle against a transaction-timed model plus directed vectors.
module tb_cell_editor;
    localparam int L0 = 1;
    localparam int L1 = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
    logic digitValid = 1'b0, clearReq = 1'b0, gameLocked = 1'b0;
    logic [2:0] digitIn = 3'd0;

    logic [1:0]  ramAddr [2];
    logic [23:0] ramDin  [2];
    logic [23:0] ramDout [2];
    logic        ramWe   [2];
    logic [1:0]  curRow  [2];
    logic [1:0]  curCol  [2];
    logic        busyO   [2];
    logic        rejO    [2];

    always #5 CLK = ~CLK;

    cell_editor #(.RD_LAT(L0)) dut1 (
        .CLK(CLK), .RST(RST), .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft),
        .btnRight(btnRight), .digitValid(digitValid), .digitIn(digitIn), .clearReq(clearReq),
        .gameLocked(gameLocked), .RamAddr(ramAddr[0]), .RamDatIn(ramDin[0]),
        .RamDatOut(ramDout[0]), .RamWe(ramWe[0]), .cursorRow(curRow[0]),
        .cursorCol(curCol[0]), .busy(busyO[0]), .rejected(rejO[0])
    );

    cell_editor #(.RD_LAT(L1)) dut3 (
        .CLK(CLK), .RST(RST), .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft),
        .btnRight(btnRight), .digitValid(digitValid), .digitIn(digitIn), .clearReq(clearReq),
        .gameLocked(gameLocked), .RamAddr(ramAddr[1]), .RamDatIn(ramDin[1]),
        .RamDatOut(ramDout[1]), .RamWe(ramWe[1]), .cursorRow(curRow[1]),
        .cursorCol(curCol[1]), .busy(busyO[1]), .rejected(rejO[1])
    );

    // RAM per instance: read data reflects the address presented RD_LAT cycles earlier.
    logic [23:0] ram  [2][4] = '{default: '0};
    logic [1:0]  hist [2][3] = '{default: '0};
    logic        plEn = 1'b0;
    logic [1:0]  plRow = 2'd0;
    logic [23:0] plWord = 24'd0;

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            hist[i][2] <= hist[i][1];
            hist[i][1] <= hist[i][0];
            hist[i][0] <= ramAddr[i];
            if (ramWe[i] === 1'b1) ram[i][ramAddr[i]] <= ramDout[i];
            if (plEn) ram[i][plRow] <= plWord;
        end
    end
    assign ramDin[0] = ram[0][hist[0][L0-1]];
    assign ramDin[1] = ram[1][hist[1][L1-1]];

    // Reference model: an edit accepted in cycle t occupies t+1..t+lat+2 and lands at t+lat+2.
    int          cyc = 0;
    int          wrAt [2] = '{-1, -1};
    int          accAt[2] = '{-1, -1};
    logic [1:0]  mRow [2] = '{2'd0, 2'd0};
    logic [1:0]  mCol [2] = '{2'd0, 2'd0};
    logic [1:0]  eRow [2] = '{2'd0, 2'd0};
    logic [1:0]  eCol [2] = '{2'd0, 2'd0};
    logic        eClr [2] = '{1'b0, 1'b0};
    logic [2:0]  eDig [2] = '{3'd0, 3'd0};
    logic [23:0] mem  [2][4] = '{default: '0};
    logic [1:0]  xAddr[2] = '{2'd0, 2'd0};
    logic [23:0] xDat [2] = '{24'd0, 24'd0};
    logic        xWe  [2] = '{1'b0, 1'b0};
    logic        xRej [2] = '{1'b0, 1'b0};
    logic        xBusy[2] = '{1'b0, 1'b0};

    always @(posedge CLK) begin
        int lat;
        logic [23:0] w;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? L0 : L1;
            if (RST) begin
                mRow[i] = 2'd0; mCol[i] = 2'd0; wrAt[i] = -1; accAt[i] = -1;
                xAddr[i] = 2'd0; xDat[i] = 24'd0; xWe[i] = 1'b0; xRej[i] = 1'b0; xBusy[i] = 1'b0;
            end else begin
                xWe[i] = 1'b0;
                xRej[i] = 1'b0;
                if (wrAt[i] < cyc) begin
                    if (digitValid || clearReq) begin
                        accAt[i] = cyc;
                        wrAt[i]  = cyc + lat + 2;
                        eRow[i] = mRow[i]; eCol[i] = mCol[i];
                        eClr[i] = clearReq; eDig[i] = digitIn;
                        xAddr[i] = mRow[i];
                    end else begin
                        mRow[i] = 2'((int'(mRow[i]) + int'(btnDown) - int'(btnUp) + 4) % 4);
                        mCol[i] = 2'((int'(mCol[i]) + int'(btnRight) - int'(btnLeft) + 4) % 4);
                    end
                end
                if (cyc + 1 == wrAt[i]) begin
                    w = mem[i][eRow[i]];
                    if (w[20 + int'(eCol[i])] || gameLocked ||
                        (!eClr[i] && !(int'(eDig[i]) inside {[1:4]}))) begin
                        xRej[i] = 1'b1;
                    end else begin
                        w[16 + int'(eCol[i])] = eClr[i];
                        w[4 * int'(eCol[i]) +: 4] = eClr[i] ? 4'd0 : {1'b0, eDig[i]};
                        mem[i][eRow[i]] = w;
                        xWe[i] = 1'b1;
                        xDat[i] = w;
                    end
                end
                xBusy[i] = (cyc + 1 > accAt[i]) && (cyc + 1 <= wrAt[i]);
            end
            if (plEn) mem[i][plRow] = plWord;
        end
        cyc++;
    end

    int nChk = 0;
    int nErr = 0;
    bit chkEn = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chkEn) begin
            for (int i = 0; i < 2; i++) begin
                string u;
                u = (i == 0) ? "L1" : "L3";
                chk({u, ".RamAddr"},   32'(ramAddr[i]), 32'(xAddr[i]));
                chk({u, ".RamWe"},     32'(ramWe[i]),   32'(xWe[i]));
                chk({u, ".RamDatOut"}, 32'(ramDout[i]), 32'(xDat[i]));
                chk({u, ".rejected"},  32'(rejO[i]),    32'(xRej[i]));
                chk({u, ".busy"},      32'(busyO[i]),   32'(xBusy[i]));
                chk({u, ".cursorRow"}, 32'(curRow[i]),  32'(mRow[i]));
                chk({u, ".cursorCol"}, 32'(curCol[i]),  32'(mCol[i]));
            end
        end
    end

    int weTot[2] = '{0, 0};
    always @(negedge CLK) for (int i = 0; i < 2; i++) if (ramWe[i] === 1'b1) weTot[i]++;

    task automatic pulse(input logic u, input logic d, input logic l, input logic r);
        btnUp = u; btnDown = d; btnLeft = l; btnRight = r;
        @(negedge CLK);
        btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
    endtask

    task automatic doReset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic preload(input logic [1:0] row, input logic [23:0] word);
        plRow = row; plWord = word; plEn = 1'b1;
        @(negedge CLK);
        plEn = 1'b0;
    endtask

    task automatic chkCursor(input string nm, input logic [1:0] r, input logic [1:0] c);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_row"}, 32'(curRow[i]), 32'(r));
            chk({nm, "_col"}, 32'(curCol[i]), 32'(c));
        end
    endtask

    typedef struct {
        logic [1:0]  row;
        logic [1:0]  col;
        logic [23:0] word;
        logic        dv;
        logic        cl;
        logic [2:0]  dig;
        logic        lock;
        logic        expWe;
        logic [23:0] expDat;
    } vec_t;

    vec_t vt[9];
    int weCnt[2], rejCnt[2], busyCnt[2], weAt[2], rejAt[2];
    logic [23:0] wDat[2];
    logic [1:0]  wAddr[2];
    int base[2];

    initial begin
        vt[0] = '{2'd1, 2'd2, 24'h040301, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 24'h000201};
        vt[1] = '{2'd1, 2'd0, 24'h100000, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 24'h000000};
        vt[2] = '{2'd0, 2'd0, 24'h001234, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 24'h011230};
        vt[3] = '{2'd2, 2'd3, 24'h000000, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 24'h000000};
        vt[4] = '{2'd3, 2'd1, 24'h000000, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 24'h000000};
        vt[5] = '{2'd3, 2'd1, 24'h000000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 24'h000000};
        vt[6] = '{2'd0, 2'd3, 24'h0F1234, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 24'h074234};
        vt[7] = '{2'd2, 2'd2, 24'hB00000, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 24'hB40000};
        vt[8] = '{2'd1, 2'd1, 24'h020000, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 24'h000010};

        @(negedge CLK);
        chkEn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_RamWe",     32'(ramWe[i]),   32'd0);
            chk("rst_RamDatOut", 32'(ramDout[i]), 32'd0);
            chk("rst_busy",      32'(busyO[i]),   32'd0);
        end
        chkCursor("rst", 2'd0, 2'd0);
        RST = 1'b0;

        // Cursor wrap and simultaneous pulses
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chkCursor("wrap_left", 2'd0, 2'd3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chkCursor("wrap_up", 2'd3, 2'd3);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        chkCursor("down_right", 2'd0, 2'd0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chkCursor("up_down_cancel", 2'd0, 2'd0);
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        chkCursor("left_right_cancel", 2'd1, 2'd0);

        foreach (vt[n]) begin
            doReset();
            gameLocked = vt[n].lock;
            preload(vt[n].row, vt[n].word);
            repeat (int'(vt[n].row)) pulse(1'b0, 1'b1, 1'b0, 1'b0);
            repeat (int'(vt[n].col)) pulse(1'b0, 1'b0, 1'b0, 1'b1);
            digitValid = vt[n].dv; clearReq = vt[n].cl; digitIn = vt[n].dig;
            @(negedge CLK);
            digitValid = 1'b0; clearReq = 1'b0;
            for (int i = 0; i < 2; i++) begin
                weCnt[i] = 0; rejCnt[i] = 0; busyCnt[i] = 0; weAt[i] = 0; rejAt[i] = 0;
                wDat[i] = 24'd0; wAddr[i] = 2'd0;
            end
            for (int k = 1; k <= 8; k++) begin
                for (int i = 0; i < 2; i++) begin
                    if (ramWe[i]) begin
                        weCnt[i]++; weAt[i] = k; wDat[i] = ramDout[i]; wAddr[i] = ramAddr[i];
                    end
                    if (rejO[i]) begin rejCnt[i]++; rejAt[i] = k; end
                    if (busyO[i]) busyCnt[i]++;
                end
                @(negedge CLK);
            end
            for (int i = 0; i < 2; i++) begin
                int lat;
                lat = (i == 0) ? L0 : L1;
                chk($sformatf("vec%0d.u%0d.weCount", n, i), 32'(weCnt[i]), 32'(vt[n].expWe));
                chk($sformatf("vec%0d.u%0d.rejCount", n, i), 32'(rejCnt[i]), 32'(!vt[n].expWe));
                chk($sformatf("vec%0d.u%0d.busyCycles", n, i), 32'(busyCnt[i]), 32'(lat + 2));
                if (vt[n].expWe) begin
                    chk($sformatf("vec%0d.u%0d.weCycle", n, i), 32'(weAt[i]), 32'(lat + 2));
                    chk($sformatf("vec%0d.u%0d.wrData", n, i), 32'(wDat[i]), 32'(vt[n].expDat));
                    chk($sformatf("vec%0d.u%0d.wrAddr", n, i), 32'(wAddr[i]), 32'(vt[n].row));
                end else begin
                    chk($sformatf("vec%0d.u%0d.rejCycle", n, i), 32'(rejAt[i]), 32'(lat + 2));
                end
                chk($sformatf("vec%0d.u%0d.ramRow", n, i), 32'(ram[i][vt[n].row]),
                    32'(vt[n].expWe ? vt[n].expDat : vt[n].word));
            end
            gameLocked = 1'b0;
        end

        // Pulses while busy are dropped, including a second edit request
        doReset();
        preload(2'd0, 24'h000000);
        base = weTot;
        digitValid = 1'b1; digitIn = 3'd3;
        @(negedge CLK);
        btnRight = 1'b1; digitIn = 3'd1;
        @(negedge CLK);
        btnRight = 1'b0; digitValid = 1'b0; btnLeft = 1'b1;
        @(negedge CLK);
        btnLeft = 1'b0;
        repeat (8) @(negedge CLK);
        chkCursor("busy_ignore", 2'd0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            chk("busy_single_write", 32'(weTot[i] - base[i]), 32'd1);
            chk("busy_ram", 32'(ram[i][0]), 32'h000003);
        end

        // Reset in the CAP cycle of the latency-1 instance abandons the write
        doReset();
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        preload(2'd1, 24'h000000);
        base = weTot;
        digitValid = 1'b1; digitIn = 3'd2;
        @(negedge CLK);
        digitValid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("cap_rst_we", 32'(ramWe[i]), 32'd0);
            chk("cap_rst_busy", 32'(busyO[i]), 32'd0);
        end
        chkCursor("cap_rst", 2'd0, 2'd0);
        repeat (6) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            chk("cap_rst_nowrite", 32'(weTot[i] - base[i]), 32'd0);
            chk("cap_rst_ram", 32'(ram[i][1]), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            btnUp    = ($urandom_range(0, 3) == 0);
            btnDown  = ($urandom_range(0, 3) == 0);
            btnLeft  = ($urandom_range(0, 3) == 0);
            btnRight = ($urandom_range(0, 3) == 0);
            digitValid = ($urandom_range(0, 5) == 0);
            clearReq   = ($urandom_range(0, 9) == 0);
            digitIn = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            if ($urandom_range(0, 49) == 0) gameLocked = ~gameLocked;
            RST = ($urandom_range(0, 199) == 0);
            plEn = ($urandom_range(0, 29) == 0);
            plRow = 2'($urandom_range(0, 3));
            plWord = 24'($urandom);
            plWord[23:20] = 4'($urandom) & 4'($urandom);
            @(negedge CLK);
        end
        btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
        digitValid = 1'b0; clearReq = 1'b0; RST = 1'b0; plEn = 1'b0; gameLocked = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 4; r++)
                chk($sformatf("final_ram_u%0d_r%0d", i, r), 32'(ram[i][r]), 32'(mem[i][r]));

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule
